// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin writeback arbiter mapping NREQ requesters onto 4 regfile write ports (WB_ARB_STATS_EN adds o_stall_cnt).
// Latency: ready is combinational; a grant at edge t drives o_weN/o_waddrN/o_wdataN for exactly one cycle.
// Backpressure: ready stays low when the 4 ports are exhausted or an earlier grant holds the same address.
module regfile_wb_arbiter #(
  parameter int WIDTH = 5,
  parameter int NREQ  = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NREQ-1:0]       i_req_valid,
  input  logic [NREQ*WIDTH-1:0] i_req_addr,
  input  logic [NREQ*32-1:0]    i_req_data,
  output logic [NREQ-1:0]       o_req_ready,
  output logic                  o_we0,
  output logic                  o_we1,
  output logic                  o_we2,
  output logic                  o_we3,
  output logic [WIDTH-1:0]      o_waddr0,
  output logic [WIDTH-1:0]      o_waddr1,
  output logic [WIDTH-1:0]      o_waddr2,
  output logic [WIDTH-1:0]      o_waddr3,
  output logic [31:0]           o_wdata0,
  output logic [31:0]           o_wdata1,
  output logic [31:0]           o_wdata2,
  output logic [31:0]           o_wdata3
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0]           o_stall_cnt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]          ptr_q, ptr_d;
  logic [3:0]             we_q, we_d;
  logic [WIDTH-1:0]       waddr_q [4];
  logic [WIDTH-1:0]       waddr_d [4];
  logic [31:0]            wdata_q [4];
  logic [31:0]            wdata_d [4];

  // Requesters are duplicated so the circular scan from ptr becomes a linear window.
  logic [2*NREQ-1:0]       vld2;
  logic [2*NREQ*WIDTH-1:0] addr2;
  logic [2*NREQ*32-1:0]    data2;
  logic [2*NREQ-1:0]       rdy2;
  logic [NREQ-1:0]         grant;
  logic [2:0]              nused;
  logic                    hit;
  int                      last;
  int                      nxt;

  assign vld2  = {i_req_valid, i_req_valid};
  assign addr2 = {i_req_addr, i_req_addr};
  assign data2 = {i_req_data, i_req_data};

  always_comb begin
    rdy2  = '0;
    we_d  = '0;
    nused = '0;
    hit   = 1'b0;
    last  = -1;
    nxt   = 0;
    for (int n = 0; n < 4; n++) begin
      waddr_d[n] = waddr_q[n];
      wdata_d[n] = wdata_q[n];
    end
    for (int j = 0; j < 2*NREQ; j++) begin
      if (vld2[j] && j >= int'(ptr_q) && j < int'(ptr_q) + NREQ) begin
        hit = 1'b0;
        for (int n = 0; n < 4; n++) begin
          if (n < int'(nused) && waddr_d[n] == addr2[j*WIDTH +: WIDTH]) hit = 1'b1;
        end
        if (addr2[j*WIDTH +: WIDTH] == '0) begin
          rdy2[j] = 1'b1;
          last    = j;
        end else if (nused < 3'd4 && !hit) begin
          rdy2[j]               = 1'b1;
          last                  = j;
          we_d[nused[1:0]]      = 1'b1;
          waddr_d[nused[1:0]]   = addr2[j*WIDTH +: WIDTH];
          wdata_d[nused[1:0]]   = data2[j*32 +: 32];
          nused                 = nused + 3'd1;
        end
      end
    end
    grant = rdy2[NREQ-1:0] | rdy2[2*NREQ-1:NREQ];
    ptr_d = ptr_q;
    if (last >= 0) begin
      nxt = last + 1;
      if (nxt >= NREQ) nxt = nxt - NREQ;
      ptr_d = PW'(nxt);
    end
  end

  assign o_req_ready = i_rst_n ? grant : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
      we_q  <= '0;
      for (int n = 0; n < 4; n++) begin
        waddr_q[n] <= '0;
        wdata_q[n] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      we_q  <= we_d;
      for (int n = 0; n < 4; n++) begin
        waddr_q[n] <= waddr_d[n];
        wdata_q[n] <= wdata_d[n];
      end
    end
  end

  assign o_we0    = we_q[0];
  assign o_we1    = we_q[1];
  assign o_we2    = we_q[2];
  assign o_we3    = we_q[3];
  assign o_waddr0 = waddr_q[0];
  assign o_waddr1 = waddr_q[1];
  assign o_waddr2 = waddr_q[2];
  assign o_waddr3 = waddr_q[3];
  assign o_wdata0 = wdata_q[0];
  assign o_wdata1 = wdata_q[1];
  assign o_wdata2 = wdata_q[2];
  assign o_wdata3 = wdata_q[3];

`ifdef WB_ARB_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_cnt <= '0;
    end else if (|(i_req_valid & ~grant) && o_stall_cnt != 32'hFFFF_FFFF) begin
      o_stall_cnt <= o_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, meaning the register address width.
REQ-002 The block SHALL have parameter NREQ, default 6, meaning the number of writeback requesters (legal range 4..8).
REQ-003 The block SHALL have port i_clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit, reset; asynchronous, active-low.
REQ-005 The block SHALL have port i_req_valid, input, NREQ bits, meaning per-requester writeback valid.
REQ-006 The block SHALL have port i_req_addr, input, NREQ*WIDTH bits, meaning the destination address; requester k occupies bits [k*WIDTH +: WIDTH].
REQ-007 The block SHALL have port i_req_data, input, NREQ*32 bits, meaning the write data; requester k occupies bits [k*32 +: 32].
REQ-008 The block SHALL have port o_req_ready, output, NREQ bits, meaning the combinational per-requester accept for this cycle.
REQ-009 The block SHALL have ports o_we0..o_we3, output, 1 bit each, meaning registered register-file write enables.
REQ-010 The block SHALL have ports o_waddr0..o_waddr3, output, WIDTH bits each, meaning registered write addresses.
REQ-011 The block SHALL have ports o_wdata0..o_wdata3, output, 32 bits each, meaning registered write data.

Function
REQ-012 Handshake: a transfer SHALL occur on a rising edge when i_req_valid[k] and o_req_ready[k] are both 1; requesters hold valid, addr and data stable until the transfer.
REQ-013 o_req_ready[k] SHALL be 0 whenever i_req_valid[k] is 0.
REQ-014 Arbitration SHALL scan requesters circularly starting at round-robin pointer P and grant in scan order.
REQ-015 A valid request with address 0 SHALL always be granted, consume no write port, and produce no write enable.
REQ-016 A valid nonzero-address request SHALL be granted only if fewer than 4 ports are already assigned this cycle and no earlier-granted request this cycle has the same address.
REQ-017 The same-address loser SHALL be deferred with ready 0; the regfile never sees two enables to one address in one cycle.
REQ-018 Ports SHALL be assigned in grant order: first nonzero grant to port 0, second to port 1, and so on.
REQ-019 Unused ports SHALL have o_weN=0 and hold their previous o_waddrN and o_wdataN values.
REQ-020 Latency: a transfer at edge t SHALL appear on o_weN, o_waddrN and o_wdataN from edge t until edge t+1, one cycle, so the regfile commits at edge t+1.
REQ-021 P update: if any request is granted, P SHALL become (index of last granted requester + 1) mod NREQ; otherwise P SHALL be unchanged.
REQ-022 With no valid requests, all o_weN SHALL be 0 on the next cycle.

Reset
REQ-023 Asserting i_rst_n=0 SHALL immediately, asynchronously, force P=0, o_we0..3=0, o_waddr0..3=0 and o_wdata0..3=0.
REQ-024 While i_rst_n=0, o_req_ready SHALL be all 0 and no transfer occurs; a request pending at reset is not written.
REQ-025 On the first edge after deassertion, the block SHALL arbitrate normally with P=0.

Configuration
REQ-026 Macro WB_ARB_STATS_EN SHALL be the single compile-time option.
REQ-027 With WB_ARB_STATS_EN defined, the block SHALL have output o_stall_cnt, 32 bits, reset to 0, which increments each cycle at least one valid requester has ready 0 and saturates at 32'hFFFF_FFFF.
REQ-028 Without WB_ARB_STATS_EN, the o_stall_cnt port and its logic SHALL be absent, and all other behaviour is identical.

Verification
REQ-029 Reset, then drive valid=6'b000011 with req0 (addr 5, data 32'hA) and req1 (addr 6, data 32'hB): ready=6'b000011; next cycle port0 is we=1/addr 5/data A, port1 is we=1/addr 6/data B, ports 2-3 we=0; P=2.
REQ-030 Hold all 6 valid with distinct nonzero addresses from P=0: cycle 1 grants req0-3 (ready=6'b001111) and P becomes 4; cycle 2 grants req4-5 on ports 0-1 and P becomes 0.
REQ-031 Drive req2 and req3 both with addr 9 at P=0: only req2 is granted; req3 is granted the following cycle on port 0.
REQ-032 Drive req0 with addr 0 plus req1-4 with addrs 1-4: ready=6'b011111; ports 0-3 carry addrs 1-4, and no port carries addr 0.
REQ-033 Assert i_rst_n=0 mid-cycle while we=1: o_weN drops to 0 immediately with no edge, ready is 0, and after release P=0.
REQ-034 With WB_ARB_STATS_EN defined, run the REQ-030 stimulus for 2 cycles: o_stall_cnt=1 (cycle 1 stalled, cycle 2 not).
